// File: rtl/pc_pkg.sv
// Shared definitions for the program counter sequencer: operation encodings and widths.
package pc_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
    localparam logic [OP_W-1:0] OP_INC    = 3'b001;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'b010;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'b011;
    localparam logic [OP_W-1:0] OP_CALL   = 3'b100;
    localparam logic [OP_W-1:0] OP_RET    = 3'b101;
    localparam logic [OP_W-1:0] OP_ERET   = 3'b110;
    localparam logic [OP_W-1:0] OP_RSVD   = 3'b111;

endpackage

// File: rtl/pc_return_stack.sv
// Circular hardware return-address stack; a push when full overwrites the oldest entry.
module pc_return_stack #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] top_idx;

    // ptr_q is the next free slot, so the top entry sits one below it.
    assign top_idx   = ptr_q - PTR_W'(1);
    assign pop_data  = mem_q[top_idx];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(RAS_DEPTH));
    assign overflow  = push & full;
    assign underflow = pop & ~push & empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push) begin
            mem_q[ptr_q] <= push_data;
            ptr_q        <= ptr_q + PTR_W'(1);
            if (!full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_q   <= top_idx;
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with return-address stack, stall and single-level trap entry/exit.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = 32'h0000_8000,
    parameter int unsigned     STEP        = 1,
    parameter int unsigned     RAS_DEPTH   = 8,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = 32'h0000_0004
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] in,
    input  logic             trap,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] epc,
    output logic             in_trap,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             in_trap_q, in_trap_d;
    logic             ras_err_q;
    logic             accept_trap, do_op;
    logic             push, pop;
    logic [WIDTH-1:0] pop_data;
    logic             overflow, underflow;
    logic [WIDTH-1:0] seq_pc;

    assign accept_trap = trap & ~in_trap_q;
    assign do_op       = ~accept_trap & ~stall;
    assign push        = do_op & (op == OP_CALL);
    assign pop         = do_op & (op == OP_RET);
    assign seq_pc      = out_q + STEP_W;

    pc_return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .pop_data  (pop_data),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_comb begin
        out_d     = out_q;
        epc_d     = epc_q;
        in_trap_d = in_trap_q;
        if (accept_trap) begin
            epc_d     = out_q;
            out_d     = TRAP_VECTOR;
            in_trap_d = 1'b1;
        end else if (!stall) begin
            case (op)
                OP_HOLD:   out_d = out_q;
                OP_INC:    out_d = seq_pc;
                OP_JUMP:   out_d = in;
                OP_BRANCH: out_d = out_q + in;
                OP_CALL:   out_d = in;
                // An empty stack falls through to the next instruction.
                OP_RET:    out_d = ras_empty ? seq_pc : pop_data;
                OP_ERET: begin
                    if (in_trap_q) begin
                        out_d     = epc_q;
                        in_trap_d = 1'b0;
                    end else begin
                        out_d = seq_pc;
                    end
                end
                default:   out_d = out_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= RESET_VALUE;
            epc_q     <= '0;
            in_trap_q <= 1'b0;
            ras_err_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            epc_q     <= epc_d;
            in_trap_q <= in_trap_d;
            ras_err_q <= ras_err_q | overflow | underflow;
        end
    end

    assign out     = out_q;
    assign epc     = epc_q;
    assign in_trap = in_trap_q;
    assign ras_err = ras_err_q;

endmodule
